// File: rtl/pcihellocore_hex_display_ctrl.sv
// Avalon-MM controller for active-low 7-segment digits. Supports raw and hex-decode modes,
// per-digit blink, and a FIFO that scrolls segment bytes into the display at a fixed rate.
module pcihellocore_hex_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int BLINK_DIV  = 25000000,
  parameter int SCROLL_DIV = 50000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [8*NUM_DIGITS-1:0] out_port
);

  localparam int          PW          = $clog2(FIFO_DEPTH);
  localparam int          VW          = 4 * NUM_DIGITS;
  localparam logic [31:0] BLINK_LAST  = 32'(BLINK_DIV - 1);
  localparam logic [31:0] SCROLL_LAST = 32'(SCROLL_DIV - 1);
  localparam logic [PW:0] LEVEL_FULL  = (PW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_VALUE  = 3'd1;
  localparam logic [2:0] A_RAW_LO = 3'd2;
  localparam logic [2:0] A_RAW_HI = 3'd3;
  localparam logic [2:0] A_MASK   = 3'd4;
  localparam logic [2:0] A_PUSH   = 3'd5;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0:    hex_seg = 8'hC0;
      4'h1:    hex_seg = 8'hF9;
      4'h2:    hex_seg = 8'hA4;
      4'h3:    hex_seg = 8'hB0;
      4'h4:    hex_seg = 8'h99;
      4'h5:    hex_seg = 8'h92;
      4'h6:    hex_seg = 8'h82;
      4'h7:    hex_seg = 8'hF8;
      4'h8:    hex_seg = 8'h80;
      4'h9:    hex_seg = 8'h90;
      4'hA:    hex_seg = 8'h88;
      4'hB:    hex_seg = 8'h83;
      4'hC:    hex_seg = 8'hC6;
      4'hD:    hex_seg = 8'hA1;
      4'hE:    hex_seg = 8'h86;
      default: hex_seg = 8'h8E;
    endcase
  endfunction

  logic                  mode, blink_en, scroll_en;
  logic [VW-1:0]         value_q;
  logic [NUM_DIGITS-1:0] blink_mask;
  logic [7:0]            raw_q [NUM_DIGITS];
  logic [7:0]            raw_d [NUM_DIGITS];
  logic [63:0]           raw_flat;
  logic [31:0]           blink_cnt, scroll_cnt;
  logic                  phase;

  logic [7:0]            fifo_mem [FIFO_DEPTH];
  logic [PW:0]           wr_ptr, rd_ptr, level;
  logic                  ovf, full, empty;

  logic wr, wr_ctrl, wr_raw_lo, wr_raw_hi, wr_push;
  logic fifo_clr, tick, pop, push;
  logic [7:0] pop_byte;
  logic [8*NUM_DIGITS-1:0] out_d;

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr && (address == A_CTRL);
  assign wr_raw_lo = wr && (address == A_RAW_LO);
  assign wr_raw_hi = wr && (address == A_RAW_HI);
  assign wr_push   = wr && (address == A_PUSH);

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (level == '0);
  assign full     = (level == LEVEL_FULL);
  assign fifo_clr = wr_ctrl && writedata[3];
  assign tick     = scroll_en && (scroll_cnt == SCROLL_LAST);
  assign pop      = tick && !empty && !fifo_clr;
  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign push     = wr_push && (!full || pop);
  assign pop_byte = fifo_mem[rd_ptr[PW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode       <= 1'b0;
      blink_en   <= 1'b0;
      scroll_en  <= 1'b0;
      value_q    <= '0;
      blink_mask <= '0;
    end else if (wr) begin
      unique case (address)
        A_CTRL:  {scroll_en, blink_en, mode} <= writedata[2:0];
        A_VALUE: value_q <= writedata[VW-1:0];
        A_MASK:  blink_mask <= writedata[NUM_DIGITS-1:0];
        default: ;
      endcase
    end
  end

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    raw_d = raw_q;
    if (pop) begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) raw_d[i] = raw_q[i-1];
      raw_d[0] = pop_byte;
    end
    // Bus writes land on top of the shifted image.
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i < 4) ? wr_raw_lo : wr_raw_hi) raw_d[i] = writedata[8*(i%4) +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) raw_q[i] <= 8'h40;
    end else begin
      raw_q <= raw_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || fifo_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_push && full && !pop) ovf <= 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= writedata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset || !blink_en) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !scroll_en) scroll_cnt <= '0;
    else if (tick)           scroll_cnt <= '0;
    else                     scroll_cnt <= scroll_cnt + 32'd1;
  end

  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      out_d[8*i +: 8] = mode ? hex_seg(value_q[4*i +: 4]) : raw_q[i];
      if (phase && blink_mask[i]) out_d[8*i +: 8] = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) out_port <= {NUM_DIGITS{8'h40}};
    else       out_port <= out_d;
  end

  always_comb begin
    raw_flat = '0;
    for (int i = 0; i < NUM_DIGITS; i++) raw_flat[8*i +: 8] = raw_q[i];
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      A_CTRL:   readdata[2:0] = {scroll_en, blink_en, mode};
      A_VALUE:  readdata[VW-1:0] = value_q;
      A_RAW_LO: readdata = raw_flat[31:0];
      A_RAW_HI: readdata = raw_flat[63:32];
      A_MASK:   readdata[NUM_DIGITS-1:0] = blink_mask;
      A_PUSH:   readdata = {13'b0, ovf, empty, full, 16'(level)};
      default:  readdata = '0;
    endcase
  end

endmodule
